// File: rtl/ped_signal_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : ped_signal_controller_if
//  Brief    : Light codes, push buttons and crossing indications for the
//             pedestrian signal controller.
//  Revision : 1.0
// ============================================================================
interface ped_signal_controller_if;
    logic [1:0] NS_light;
    logic [1:0] EW_light;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       walk_ns;
    logic       walk_ew;
    logic       flash_ns;
    logic       flash_ew;
    logic       pending_ns;
    logic       pending_ew;
    logic [3:0] countdown_ns;
    logic [3:0] countdown_ew;
    logic       fault;

    modport master (
        output NS_light, EW_light, ped_req_ns, ped_req_ew,
        input  walk_ns, walk_ew, flash_ns, flash_ew,
        input  pending_ns, pending_ew, countdown_ns, countdown_ew, fault
    );

    modport slave (
        input  NS_light, EW_light, ped_req_ns, ped_req_ew,
        output walk_ns, walk_ew, flash_ns, flash_ew,
        output pending_ns, pending_ew, countdown_ns, countdown_ew, fault
    );
endinterface
`default_nettype wire

// File: rtl/ped_signal_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ped_signal_controller
//  Brief    : Walk / flashing don't-walk sequencing for the NS and EW
//             crossings, driven by upstream light codes, with sticky fault.
//  Revision : 1.0
// ============================================================================
module ped_signal_controller #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    ped_signal_controller_if.slave    bus
);

    localparam logic [1:0] c_red     = 2'b00;
    localparam logic [1:0] c_yellow  = 2'b01;
    localparam logic [1:0] c_green   = 2'b10;
    localparam logic [1:0] c_illegal = 2'b11;

    localparam logic [3:0] c_walk_load  = 4'(WALK_CYCLES);
    localparam logic [3:0] c_flash_load = 4'(FLASH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WALK  = 2'd2,
        S_FLASH = 2'd3
    } state_t;

    logic [1:0] r_prev_ns;
    logic [1:0] r_prev_ew;
    logic       r_fault;

    logic       w_fault_cond;
    logic       w_kill;
    logic [1:0] w_light [2];
    logic [1:0] w_req;
    logic [1:0] w_gedge;
    logic [1:0] w_walk;
    logic [1:0] w_flash;
    logic [1:0] w_pend;
    logic [3:0] w_cd [2];

    assign w_fault_cond = (bus.NS_light == c_illegal) || (bus.EW_light == c_illegal) ||
                          ((bus.NS_light != c_red) && (bus.EW_light != c_red));
    // Once faulted, both crossings are held idle until reset.
    assign w_kill = w_fault_cond || r_fault;

    assign w_light[0] = bus.NS_light;
    assign w_light[1] = bus.EW_light;
    assign w_req[0]   = bus.ped_req_ns;
    assign w_req[1]   = bus.ped_req_ew;
    assign w_gedge[0] = (r_prev_ns != c_green) && (bus.NS_light == c_green);
    assign w_gedge[1] = (r_prev_ew != c_green) && (bus.EW_light == c_green);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_ns <= c_red;
            r_prev_ew <= c_red;
            r_fault   <= 1'b0;
        end else begin
            r_prev_ns <= bus.NS_light;
            r_prev_ew <= bus.EW_light;
            r_fault   <= r_fault | w_fault_cond;
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_xing
            state_t     r_state;
            logic [3:0] r_cnt;
            logic       r_pend;
            logic       r_walk;
            logic       r_flash;
            logic [3:0] r_cd;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_pend  <= 1'b0;
                    r_walk  <= 1'b0;
                    r_flash <= 1'b0;
                    r_cd    <= 4'd0;
                end else if (w_kill) begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_pend  <= 1'b0;
                    r_walk  <= 1'b0;
                    r_flash <= 1'b0;
                    r_cd    <= 4'd0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            // A request coinciding with a green edge is only latched here.
                            if (w_req[i]) begin
                                r_state <= S_WAIT;
                                r_pend  <= 1'b1;
                            end
                        end
                        S_WAIT: begin
                            if (w_gedge[i]) begin
                                r_state <= S_WALK;
                                r_cnt   <= c_walk_load;
                                r_pend  <= 1'b0;
                                r_walk  <= 1'b1;
                            end
                        end
                        S_WALK: begin
                            r_pend <= r_pend | w_req[i];
                            if (w_light[i] == c_red) begin
                                r_state <= S_IDLE;
                                r_cnt   <= 4'd0;
                                r_pend  <= 1'b0;
                                r_walk  <= 1'b0;
                            end else if ((w_light[i] == c_yellow) || (r_cnt == 4'd1)) begin
                                r_state <= S_FLASH;
                                r_cnt   <= c_flash_load;
                                r_walk  <= 1'b0;
                                r_flash <= 1'b1;
                                r_cd    <= c_flash_load;
                            end else begin
                                r_cnt <= r_cnt - 4'd1;
                            end
                        end
                        S_FLASH: begin
                            if ((w_light[i] == c_red) || (r_cnt == 4'd1)) begin
                                r_cnt   <= 4'd0;
                                r_flash <= 1'b0;
                                r_cd    <= 4'd0;
                                if (r_pend || w_req[i]) begin
                                    r_state <= S_WAIT;
                                    r_pend  <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_cnt  <= r_cnt - 4'd1;
                                r_cd   <= r_cnt - 4'd1;
                                r_pend <= r_pend | w_req[i];
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end

            assign w_walk[i]  = r_walk;
            assign w_flash[i] = r_flash;
            assign w_pend[i]  = r_pend;
            assign w_cd[i]    = r_cd;
        end
    endgenerate

    assign bus.walk_ns      = w_walk[0];
    assign bus.walk_ew      = w_walk[1];
    assign bus.flash_ns     = w_flash[0];
    assign bus.flash_ew     = w_flash[1];
    assign bus.pending_ns   = w_pend[0];
    assign bus.pending_ew   = w_pend[1];
    assign bus.countdown_ns = w_cd[0];
    assign bus.countdown_ew = w_cd[1];
    assign bus.fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ped_signal_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ped_signal_controller
//  Brief    : Scoreboard bench for ped_signal_controller using a remaining-
//             cycles reference model and randomized traffic/requests.
//  Revision : 1.0
// ============================================================================
module tb_ped_signal_controller;

    localparam int W = 8;
    localparam int F = 6;
    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic rst_next;
    always #5 clk = ~clk;

    ped_signal_controller_if bus ();

    ped_signal_controller #(
        .WALK_CYCLES  (W),
        .FLASH_CYCLES (F)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       fault;
        logic [1:0] walk;
        logic [1:0] flash;
        logic [1:0] pend;
        logic [3:0] cd_ns;
        logic [3:0] cd_ew;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e;
    obs_t mon_g;
    obs_t asy_g;
    int   checks = 0;
    int   errors = 0;

    // Reference model: each crossing is a pending flag plus remaining walk/flash cycles.
    logic [1:0] m_prev [2];
    logic       m_fault;
    logic       m_pend [2];
    int         m_walk_left [2];
    int         m_flash_left [2];

    function automatic obs_t observe();
        obs_t o;
        o.fault = bus.fault;
        o.walk  = {bus.walk_ew, bus.walk_ns};
        o.flash = {bus.flash_ew, bus.flash_ns};
        o.pend  = {bus.pending_ew, bus.pending_ns};
        o.cd_ns = bus.countdown_ns;
        o.cd_ew = bus.countdown_ew;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.fault = m_fault;
        for (int i = 0; i < 2; i++) begin
            o.walk[i]  = (m_walk_left[i] > 0);
            o.flash[i] = (m_flash_left[i] > 0);
            o.pend[i]  = m_pend[i];
        end
        o.cd_ns = 4'(m_flash_left[0]);
        o.cd_ew = 4'(m_flash_left[1]);
        return o;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_pend[i]       = 1'b0;
            m_walk_left[i]  = 0;
            m_flash_left[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_prev[0] = R;
        m_prev[1] = R;
        m_fault   = 1'b0;
        model_clear();
    endtask

    task automatic model_edge(input logic [1:0] ns, input logic [1:0] ew,
                              input logic rq_ns, input logic rq_ew);
        logic [1:0] lt [2];
        logic       rq [2];
        logic       ge [2];
        logic       bad;
        lt[0] = ns;  lt[1] = ew;
        rq[0] = rq_ns; rq[1] = rq_ew;
        for (int i = 0; i < 2; i++) ge[i] = (m_prev[i] != G) && (lt[i] == G);
        bad = (ns == 2'b11) || (ew == 2'b11) || (ns != R && ew != R);
        m_prev[0] = ns;
        m_prev[1] = ew;
        if (bad || m_fault) begin
            m_fault = 1'b1;
            model_clear();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_walk_left[i] > 0) begin
                if (lt[i] == R) begin
                    m_walk_left[i] = 0;
                    m_pend[i]      = 1'b0;
                end else begin
                    m_pend[i] = m_pend[i] | rq[i];
                    if (lt[i] == Y || m_walk_left[i] == 1) begin
                        m_walk_left[i]  = 0;
                        m_flash_left[i] = F;
                    end else begin
                        m_walk_left[i] = m_walk_left[i] - 1;
                    end
                end
            end else if (m_flash_left[i] > 0) begin
                m_pend[i] = m_pend[i] | rq[i];
                if (lt[i] == R || m_flash_left[i] == 1) m_flash_left[i] = 0;
                else m_flash_left[i] = m_flash_left[i] - 1;
            end else if (m_pend[i] && ge[i]) begin
                m_walk_left[i] = W;
                m_pend[i]      = 1'b0;
            end else begin
                m_pend[i] = m_pend[i] | rq[i];
            end
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input logic [1:0] ns, input logic [1:0] ew,
                        input logic rq_ns, input logic rq_ew);
        @(negedge clk);
        rst            = rst_next;
        bus.NS_light   = ns;
        bus.EW_light   = ew;
        bus.ped_req_ns = rq_ns;
        bus.ped_req_ew = rq_ew;
        if (rst) model_reset();
        else model_edge(ns, ew, rq_ns, rq_ew);
        exp_q.push_back(model_obs());
    endtask

    task automatic hold(input logic [1:0] ns, input logic [1:0] ew, input int n, input int pct);
        for (int k = 0; k < n; k++)
            step(ns, ew, ($urandom_range(99) < pct), ($urandom_range(99) < pct));
    endtask

    task automatic traffic_round(input int pct);
        hold(G, R, $urandom_range(1, 14), pct);
        hold(Y, R, $urandom_range(1, 3), pct);
        hold(R, R, $urandom_range(0, 2), pct);
        hold(R, G, $urandom_range(1, 14), pct);
        hold(R, Y, $urandom_range(1, 3), pct);
        hold(R, R, $urandom_range(0, 2), pct);
    endtask

    // Mid-cycle reset: outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        asy_g = observe();
        checks++;
        if (asy_g !== '0) begin
            errors++;
            $display("FAIL async_reset_clear: got %h required 0", asy_g);
        end
        model_reset();
        exp_q.push_back(model_obs());
        rst_next = 1'b1;
        step(R, R, 1'b0, 1'b0);
        rst_next = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_g = observe();
                checks++;
                if (mon_g !== mon_e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got fault=%b walk=%b flash=%b pend=%b cd_ns=%0d cd_ew=%0d required fault=%b walk=%b flash=%b pend=%b cd_ns=%0d cd_ew=%0d",
                             $time, mon_g.fault, mon_g.walk, mon_g.flash, mon_g.pend, mon_g.cd_ns, mon_g.cd_ew,
                             mon_e.fault, mon_e.walk, mon_e.flash, mon_e.pend, mon_e.cd_ns, mon_e.cd_ew);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        rst_next       = 1'b1;
        bus.NS_light   = R;
        bus.EW_light   = R;
        bus.ped_req_ns = 1'b0;
        bus.ped_req_ew = 1'b0;
        model_reset();

        // Reset held with random inputs
        repeat (3) step(2'($urandom_range(3)), 2'($urandom_range(3)),
                        1'($urandom_range(1)), 1'($urandom_range(1)));
        rst_next = 1'b0;

        // Basic NS service
        step(R, G, 1'b1, 1'b0);
        hold(R, G, 2, 0);
        hold(G, R, 20, 0);
        hold(Y, R, 2, 0);
        hold(R, R, 1, 0);

        // Early yellow during walk
        step(R, R, 1'b1, 1'b0);
        hold(G, R, 4, 0);
        hold(Y, R, 8, 0);
        hold(R, R, 2, 0);

        // EW request while already green, then service on the next green
        hold(R, G, 3, 0);
        step(R, G, 1'b0, 1'b1);
        hold(R, G, 5, 0);
        hold(R, Y, 2, 0);
        hold(R, R, 1, 0);
        hold(G, R, 3, 0);
        hold(Y, R, 1, 0);
        hold(R, R, 1, 0);
        hold(R, G, 10, 0);
        step(R, G, 1'b0, 1'b1);
        hold(R, G, 12, 0);
        hold(R, Y, 1, 0);
        hold(R, R, 1, 0);
        hold(R, G, 16, 0);

        // Conflict during NS walk, then requests are ignored until reset
        step(R, R, 1'b1, 1'b0);
        hold(G, R, 3, 0);
        step(G, Y, 1'b0, 1'b0);
        repeat (2) traffic_round(30);
        async_reset();

        // Illegal code
        step(2'b11, R, 1'b0, 1'b0);
        hold(R, R, 3, 50);
        async_reset();

        // Randomized traffic with occasional illegal inputs and resets
        repeat (60) begin
            traffic_round(25);
            if ($urandom_range(9) == 0)
                step(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b0, 1'b0);
            if (m_fault && $urandom_range(2) == 0) async_reset();
            else if ($urandom_range(29) == 0) async_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
